cp0_regfile: RTL and testbench
==============================

CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have ports we_i (input, 1), waddr_i (input, 5) and wdata_i (input, 32), the mtc0 write port.
REQ-004 SHALL have ports raddr_i (input, 5) and rdata_o (output, 32), the mfc0 read port; the read is combinational from the registers.
REQ-005 SHALL have port int_i, input, 6, hardware interrupt lines 5..0, level sensitive.
REQ-006 SHALL have port excepttype_i, input, 32, the encoded exception: 0 none, 1 Int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, 0xa RI, 0xc Ov, 0xe eret.
REQ-007 SHALL have ports except_pc_i (input, 32), in_delayslot_i (input, 1) and bad_addr_i (input, 32).
REQ-008 SHALL have outputs status_o, cause_o, epc_o, badvaddr_o, count_o and compare_o (each 32), plus timer_int_o (1).

Function
REQ-009 SHALL map register numbers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC; any other number reads 0 and ignores writes.
REQ-010 SHALL limit mtc0 writes to these fields: Status[15:8] IM, Status[1] EXL, Status[0] IE; Cause[9:8]; EPC, Count and Compare in full; BadVAddr is read-only.
REQ-011 SHALL hold Status[22] BEV at 1; every other unlisted bit SHALL be held at 0.
REQ-012 SHALL register Cause[15:10] every cycle as int_i[5:0], with bit 15 ORed with timer_int_o.
REQ-013 SHALL, on an exception code other than 0 or 0xe while Status.EXL=0: EPC = in_delayslot_i ? except_pc_i-4 : except_pc_i; Cause[31] = in_delayslot_i.
REQ-014 SHALL, on any exception code other than 0 or 0xe, set Cause[6:2] = code[4:0] and Status.EXL = 1.
REQ-015 SHALL, on an exception code other than 0 or 0xe while Status.EXL=1, leave EPC and Cause[31] unchanged.
REQ-016 SHALL, on codes 4 and 5, load BadVAddr with bad_addr_i; it is unchanged for all other codes.
REQ-017 SHALL clear Status.EXL on code 0xe (eret); no other register changes.
REQ-018 SHALL, when an mtc0 and an exception occur in the same cycle, apply the write first and let the exception update override any overlapping field.
REQ-019 SHALL return pre-write register values on rdata_o; there is no write-to-read forwarding.
REQ-020 SHALL make every output visible one cycle after the triggering edge.

Reset
REQ-021 SHALL, while resetn=0, force Status=0x0040_0000, and Cause, EPC, BadVAddr, Count and Compare all to 0.
REQ-022 SHALL, while resetn=0, force timer_int_o=0 and the count divider to 0.
REQ-023 SHALL treat reset asserted mid-operation (an exception or write in progress) as taking effect immediately; no update completes.

Configuration
REQ-024 SHALL, with CP0_TIMER_EN defined, increment Count on every second clk edge via a 1-bit divider.
REQ-025 SHALL, with CP0_TIMER_EN defined, let an mtc0 to Count load the value and clear the divider.
REQ-026 SHALL, with CP0_TIMER_EN defined, set timer_int_o when Count==Compare and Compare!=0; timer_int_o stays set until an mtc0 to Compare clears it.
REQ-027 SHALL let Count wrap from 0xFFFF_FFFF to 0.
REQ-028 SHALL, without CP0_TIMER_EN, read Count and Compare as 0, drop writes to them, tie timer_int_o to 0, and set Cause[15] = int_i[5] only.

Structure
REQ-029 SHALL place the register numbers, ExcCode constants, Status reset value and field bit positions in shared package cp0_pkg.
REQ-030 SHALL implement Count, Compare, the divider and timer_int in sub-module cp0_timer, instantiated only under CP0_TIMER_EN.

Verification
REQ-031 SHALL cover: reset released -> status_o=0x0040_0000, all other outputs 0.
REQ-032 SHALL cover: excepttype_i=0x8, except_pc_i=0xBFC0_0100, in_delayslot_i=1 -> epc_o=0xBFC0_00FC, cause_o[31]=1, cause_o[6:2]=8, status_o[1]=1.
REQ-033 SHALL cover: with EXL=1, excepttype_i=0xc at pc 0x100 -> epc_o unchanged, cause_o[6:2]=0xc; then excepttype_i=0xe -> status_o[1]=0.
REQ-034 SHALL cover: excepttype_i=0x4, bad_addr_i=0x8000_0003 -> badvaddr_o=0x8000_0003, cause_o[6:2]=4.
REQ-035 SHALL cover, with CP0_TIMER_EN: write Compare=4, Count=0 -> timer_int_o=1 and cause_o[15]=1 about 8 cycles later; rewrite Compare -> timer_int_o=0 next cycle.
REQ-036 SHALL cover: same-cycle mtc0 EPC=0x1234 and excepttype_i=0x9 at pc 0x200 with EXL=0 -> epc_o=0x200.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause field
// positions and the Status reset value.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'ha;
  localparam logic [31:0] EXC_OV   = 32'hc;
  localparam logic [31:0] EXC_ERET = 32'he;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  localparam int STATUS_IM_HI = 15;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IE    = 0;

  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IPH_HI = 15;
  localparam int CAUSE_IPH_LO = 10;
  localparam int CAUSE_IPS_HI = 9;
  localparam int CAUSE_IPS_LO = 8;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

  // Assemble the architectural Status word; BEV and zero bits come from the reset value.
  function automatic logic [31:0] pack_status(input logic [7:0] im, input logic exl,
                                              input logic ie);
    logic [31:0] s;
    s = STATUS_RESET;
    s[STATUS_IM_HI:STATUS_IM_LO] = im;
    s[STATUS_EXL] = exl;
    s[STATUS_IE]  = ie;
    return s;
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip_hw,
                                             input logic [1:0] ip_sw, input logic [4:0] exc);
    logic [31:0] c;
    c = '0;
    c[CAUSE_BD] = bd;
    c[CAUSE_IPH_HI:CAUSE_IPH_LO] = ip_hw;
    c[CAUSE_IPS_HI:CAUSE_IPS_LO] = ip_sw;
    c[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc;
    return c;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second clk edge, timer_int
// latches on Count==Compare (Compare!=0) until Compare is rewritten.
module cp0_timer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic div;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count     <= '0;
      compare   <= '0;
      div       <= 1'b0;
      timer_int <= 1'b0;
    end else begin
      if (we_count) begin
        count <= wdata;
        div   <= 1'b0;
      end else begin
        div <= ~div;
        if (div) count <= count + 32'd1;
      end
      if (we_compare) begin
        compare   <= wdata;
        timer_int <= 1'b0;
      end else if (count == compare && compare != '0) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC).
// Define CP0_TIMER_EN to build the Count/Compare timer; otherwise both read 0.
module cp0_regfile
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] except_pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic        timer_int;

  logic is_exc, is_eret, is_addr_exc;
  logic wr_status, wr_cause, wr_epc;

  assign is_exc      = (excepttype_i != EXC_NONE) && (excepttype_i != EXC_ERET);
  assign is_eret     = (excepttype_i == EXC_ERET);
  assign is_addr_exc = (excepttype_i == EXC_ADEL) || (excepttype_i == EXC_ADES);
  assign wr_status   = we_i && (waddr_i == REG_STATUS);
  assign wr_cause    = we_i && (waddr_i == REG_CAUSE);
  assign wr_epc      = we_i && (waddr_i == REG_EPC);

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .we_count   (we_i && (waddr_i == REG_COUNT)),
    .we_compare (we_i && (waddr_i == REG_COMPARE)),
    .wdata      (wdata_i),
    .count      (count_o),
    .compare    (compare_o),
    .timer_int  (timer_int)
  );
`else
  assign count_o   = '0;
  assign compare_o = '0;
  assign timer_int = 1'b0;
`endif

  // Later assignments win: the mtc0 write lands first and the exception/eret overrides it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_im   <= '0;
      status_exl  <= 1'b0;
      status_ie   <= 1'b0;
      cause_bd    <= 1'b0;
      cause_ip_hw <= '0;
      cause_ip_sw <= '0;
      cause_exc   <= '0;
      epc_q       <= '0;
      badvaddr_q  <= '0;
    end else begin
      cause_ip_hw <= {int_i[5] | timer_int, int_i[4:0]};
      if (wr_status) begin
        status_im  <= wdata_i[STATUS_IM_HI:STATUS_IM_LO];
        status_exl <= wdata_i[STATUS_EXL];
        status_ie  <= wdata_i[STATUS_IE];
      end
      if (wr_cause) cause_ip_sw <= wdata_i[CAUSE_IPS_HI:CAUSE_IPS_LO];
      if (wr_epc)   epc_q       <= wdata_i;
      if (is_exc) begin
        status_exl <= 1'b1;
        cause_exc  <= excepttype_i[4:0];
        // A nested exception keeps the original return point.
        if (!status_exl) begin
          epc_q    <= in_delayslot_i ? except_pc_i - 32'd4 : except_pc_i;
          cause_bd <= in_delayslot_i;
        end
        if (is_addr_exc) badvaddr_q <= bad_addr_i;
      end else if (is_eret) begin
        status_exl <= 1'b0;
      end
    end
  end

  assign status_o    = pack_status(status_im, status_exl, status_ie);
  assign cause_o     = pack_cause(cause_bd, cause_ip_hw, cause_ip_sw, cause_exc);
  assign epc_o       = epc_q;
  assign badvaddr_o  = badvaddr_q;
  assign timer_int_o = timer_int;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      REG_BADVADDR: rdata_o = badvaddr_q;
      REG_COUNT:    rdata_o = count_o;
      REG_COMPARE:  rdata_o = compare_o;
      REG_STATUS:   rdata_o = status_o;
      REG_CAUSE:    rdata_o = cause_o;
      REG_EPC:      rdata_o = epc_q;
      default:      rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios plus randomized traffic
// compared against a word-level reference model. Define CP0_TIMER_EN for timer tests.
module tb_cp0_regfile;

`ifdef CP0_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] except_pc_i;
  logic        in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;
  logic        timer_int_o;

  int n_checks = 0;
  int n_errors = 0;

  cp0_regfile dut (
    .clk            (clk),
    .resetn         (resetn),
    .we_i           (we_i),
    .waddr_i        (waddr_i),
    .wdata_i        (wdata_i),
    .raddr_i        (raddr_i),
    .rdata_o        (rdata_o),
    .int_i          (int_i),
    .excepttype_i   (excepttype_i),
    .except_pc_i    (except_pc_i),
    .in_delayslot_i (in_delayslot_i),
    .bad_addr_i     (bad_addr_i),
    .status_o       (status_o),
    .cause_o        (cause_o),
    .epc_o          (epc_o),
    .badvaddr_o     (badvaddr_o),
    .count_o        (count_o),
    .compare_o      (compare_o),
    .timer_int_o    (timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: whole architectural words; Count is base + half the elapsed cycles.
  logic [31:0] m_status, m_cause, m_epc, m_bad, m_base, m_compare;
  int unsigned m_elapsed;
  logic        m_tint;

  function automatic logic [31:0] m_count();
    return TIMER ? m_base + 32'(m_elapsed >> 1) : 32'h0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count();
      5'd11:   return TIMER ? m_compare : 32'h0;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_bad = 0;
    m_base = 0; m_compare = 0; m_elapsed = 0; m_tint = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".status"},   status_o,   m_status);
    check({tag, ".cause"},    cause_o,    m_cause);
    check({tag, ".epc"},      epc_o,      m_epc);
    check({tag, ".badvaddr"}, badvaddr_o, m_bad);
    check({tag, ".count"},    count_o,    m_count());
    check({tag, ".compare"},  compare_o,  TIMER ? m_compare : 32'h0);
    check({tag, ".timer"},    {31'b0, timer_int_o}, {31'b0, TIMER ? m_tint : 1'b0});
  endtask

  // One clock: check the combinational read, advance model and DUT, check all outputs.
  task automatic step(input string tag);
    logic [31:0] n_status, n_cause, n_epc, n_bad, n_base, n_compare, code, ip;
    int unsigned n_elapsed;
    logic n_tint, exc;
    #1;
    check({tag, ".rdata"}, rdata_o, m_read(raddr_i));
    n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_bad = m_bad;
    n_base = m_base; n_compare = m_compare; n_elapsed = m_elapsed + 1;
    n_tint = m_tint || (m_count() == m_compare && m_compare != 0);
    code = excepttype_i;
    exc  = (code != 0) && (code != 32'he);
    if (we_i) begin
      case (waddr_i)
        5'd9:  begin n_base = wdata_i; n_elapsed = 0; end
        5'd11: begin n_compare = wdata_i; n_tint = 1'b0; end
        5'd12: n_status = (wdata_i & 32'h0000_ff03) | 32'h0040_0000;
        5'd13: n_cause = (n_cause & ~32'h300) | (wdata_i & 32'h300);
        5'd14: n_epc = wdata_i;
        default: ;
      endcase
    end
    ip = 32'({int_i[5] | (TIMER & m_tint), int_i[4:0]}) << 10;
    n_cause = (n_cause & ~32'hfc00) | ip;
    if (exc) begin
      n_status = n_status | 32'h2;
      n_cause  = (n_cause & ~32'h7c) | ({27'b0, code[4:0]} << 2);
      if (m_status[1] == 1'b0) begin
        n_epc   = in_delayslot_i ? except_pc_i - 4 : except_pc_i;
        n_cause = in_delayslot_i ? (n_cause | 32'h8000_0000) : (n_cause & 32'h7fff_ffff);
      end
      if (code == 4 || code == 5) n_bad = bad_addr_i;
    end else if (code == 32'he) begin
      n_status = n_status & ~32'h2;
    end
    @(posedge clk);
    #1;
    m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_bad = n_bad;
    m_base = n_base; m_compare = n_compare; m_elapsed = n_elapsed; m_tint = n_tint;
    check_outputs(tag);
  endtask

  task automatic idle();
    we_i = 0; waddr_i = 0; wdata_i = 0; excepttype_i = 0;
    except_pc_i = 0; in_delayslot_i = 0; bad_addr_i = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); we_i = 1; waddr_i = a; wdata_i = d;
    step("mtc0");
    idle();
  endtask

  task automatic raise(input logic [31:0] code, input logic [31:0] pc, input logic ds,
                       input logic [31:0] bad);
    idle(); excepttype_i = code; except_pc_i = pc; in_delayslot_i = ds; bad_addr_i = bad;
    step("exc");
    idle();
  endtask

  logic [4:0]  waddrs [9] = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
  logic [31:0] codes  [8] = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'he};

  initial begin
    resetn = 1'b0; int_i = 0; raddr_i = 5'd12;
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    check_outputs("reset");

    raise(32'h8, 32'hbfc0_0100, 1'b1, 32'h0);
    check("sys.epc", epc_o, 32'hbfc0_00fc);
    check("sys.bd", {31'b0, cause_o[31]}, 32'h1);
    check("sys.exccode", {27'b0, cause_o[6:2]}, 32'h8);
    check("sys.exl", {31'b0, status_o[1]}, 32'h1);

    raise(32'hc, 32'h100, 1'b0, 32'h0);
    check("ov_nested.epc", epc_o, 32'hbfc0_00fc);
    check("ov_nested.exccode", {27'b0, cause_o[6:2]}, 32'hc);
    raise(32'he, 32'h0, 1'b0, 32'h0);
    check("eret.exl", {31'b0, status_o[1]}, 32'h0);

    raise(32'h4, 32'h300, 1'b0, 32'h8000_0003);
    check("adel.badvaddr", badvaddr_o, 32'h8000_0003);
    check("adel.exccode", {27'b0, cause_o[6:2]}, 32'h4);
    raise(32'he, 32'h0, 1'b0, 32'h0);

    we_i = 1; waddr_i = 5'd14; wdata_i = 32'h1234;
    excepttype_i = 32'h9; except_pc_i = 32'h200;
    step("mtc0_vs_bp");
    idle();
    check("mtc0_vs_bp.epc", epc_o, 32'h200);
    raise(32'he, 32'h0, 1'b0, 32'h0);

    mtc0(5'd12, 32'hffff_ffff);
    check("status_mask", status_o, 32'h0040_ff03);
    mtc0(5'd12, 32'h0);

`ifdef CP0_TIMER_EN
    begin
      int k;
      mtc0(5'd11, 32'd4);
      mtc0(5'd9, 32'd0);
      k = 0;
      while (k < 20 && !timer_int_o) begin
        step("timer_wait");
        k++;
      end
      check("timer.fired", {31'b0, timer_int_o}, 32'h1);
      check("timer.window", {31'b0, k >= 6 && k <= 12}, 32'h1);
      step("timer_ip");
      check("timer.cause15", {31'b0, cause_o[15]}, 32'h1);
      mtc0(5'd11, 32'd100);
      check("timer.cleared", {31'b0, timer_int_o}, 32'h0);
      mtc0(5'd9, 32'hffff_ffff);
      step("wrap"); step("wrap");
      check("count.wrap", count_o, 32'h0);
    end
`endif

    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        excepttype_i = 32'h8; we_i = 1; waddr_i = 5'd14; wdata_i = 32'hdead_beef;
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check("midreset.status", status_o, 32'h0040_0000);
        check("midreset.epc", epc_o, 32'h0);
        @(posedge clk);
        #1;
        check_outputs("midreset_hold");
        resetn = 1'b1;
        idle();
      end
      int_i   = 6'($urandom);
      raddr_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : waddrs[$urandom_range(0, 8)];
      we_i    = ($urandom_range(0, 2) == 0);
      waddr_i = waddrs[$urandom_range(0, 8)];
      wdata_i = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      excepttype_i   = ($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 7)] : 32'h0;
      except_pc_i    = $urandom;
      in_delayslot_i = 1'($urandom);
      bad_addr_i     = $urandom;
      if (excepttype_i != 0 && waddr_i == 5'd12) we_i = 1'b0;
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
